fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Sequencing controller that shares one combinational FP32 multiplier (fp_X/fp_Y/r_mode -> fp_Z, ovrf, udrf) between two requesters.
- Arbitrates round-robin, registers and holds operands stable for the multiplier's settling latency, captures the result, and returns it on a valid/ready response channel tagged with the requester id.
- Sits between issue logic and the multiplier datapath; validates the rounding mode before issue.

Parameters:
MUL_LAT, 1, cycles operands are held before fp_Z is sampled (>=1; covers added pipeline/retiming in the multiplier)
CNT_W, $clog2(MUL_LAT+1), latency counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_x  in  32  operand X, FP32
req0_y  in  32  operand Y, FP32
req0_rmode  in  3  rounding mode
req1_valid / req1_ready / req1_x / req1_y / req1_rmode  same as requester 0
mul_x  out  32  to multiplier fp_X
mul_y  out  32  to multiplier fp_Y
mul_rmode  out  3  to multiplier r_mode
mul_z  in  32  multiplier fp_Z
mul_ovrf  in  1  multiplier overflow
mul_udrf  in  1  multiplier underflow
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the result
rsp_z  out  32  captured product
rsp_ovrf  out  1  captured overflow
rsp_udrf  out  1  captured underflow
rsp_err  out  1  illegal rounding mode rejected
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; rr_ptr=0 (req0 preferred); all outputs 0; mul_* registers 0.
- Legal r_mode values: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Values 101-111 are illegal.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - reqN_ready = grantN, and grant is only possible in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant rr_ptr's side; rr_ptr <= other side on the grant.
  - On grant: latch x/y/rmode into mul_* registers and the id into rsp_id.
  - Legal rmode: -> CALC, cnt <= 0.
  - Illegal rmode: -> DONE directly; rsp_z=32'h7fc00000, rsp_err=1, ovrf=udrf=0; multiplier not issued (mul_* still update, harmless).
- CALC:
  - mul_* held constant; cnt increments each cycle.
  - When cnt == MUL_LAT-1: capture mul_z/mul_ovrf/mul_udrf into rsp_*, rsp_err=0, -> DONE.
- DONE:
  - rsp_valid=1; rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: -> IDLE, rsp_valid deasserts next cycle.
  - No new grant in the same cycle as the rsp_ready handshake.
- Timing: accept at cycle t -> rsp_valid at t+MUL_LAT+1. Minimum issue spacing MUL_LAT+2 cycles.
- Requester side: reqN_valid may drop without acceptance; no stickiness required. Payload is sampled only on the ready cycle.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.
- Reset mid-CALC/DONE: transaction discarded, no response, rr_ptr returns to 0.
- rsp_ready asserted outside DONE is ignored.

Decomposition:
- fp_mul_ctrl_pkg holds:
  - state enum (IDLE/CALC/DONE)
  - rounding-mode localparams RM_RNE/RM_RTZ/RM_RDN/RM_RUP/RM_RMM
  - QNAN=32'h7fc00000
  - function rmode_legal()
- Sub-module rr_arb2 (2-input round-robin grant with pointer update on accept).
- Top instantiates the combinational multiplier externally; this block contains no arithmetic.

Test Plan:
- req0 x=0x40400000 y=0x40400000 rmode=001, MUL_LAT=1, rsp_ready=1 -> req0_ready at t, rsp_valid at t+2, rsp_z=0x41100000, rsp_id=0, flags 0.
- req0 and req1 held valid for 4 transactions (req1: x=0x3f800000 y=0x40490fdb) -> grant order 0,1,0,1; req1 results rsp_z=0x40490fdb, rsp_id=1.
- req1 x=0x7f000000 y=0x7f000000 rmode=000 -> rsp_z=0x7f800000, rsp_ovrf=1, rsp_id=1.
- req0 rmode=3'b110 -> rsp_valid at t+1, rsp_err=1, rsp_z=0x7fc00000; mul_z never sampled.
- rsp_ready low for 5 cycles in DONE -> rsp_* stable, req0/1_ready stay 0, busy=1; release -> IDLE next cycle, new grant the following cycle.
- MUL_LAT=3, rst_n pulsed low during CALC -> all outputs 0 immediately, no rsp_valid afterwards, next dual request grants req0.

Source files
------------

// File: rtl/fp_mul_ctrl_pkg.sv
// rtl/fp_mul_ctrl_pkg.sv - shared types, rounding-mode codes and helpers for the FP multiplier sequencer
package fp_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] QNAN = 32'h7fc00000;

  // Legal codes are contiguous from RNE up to RMM.
  function automatic logic rmode_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - requester, multiplier and response signal bundle of the FP multiplier sequencer
interface fp_mul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_x;
  logic [31:0] req0_y;
  logic [2:0]  req0_rmode;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_x;
  logic [31:0] req1_y;
  logic [2:0]  req1_rmode;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [2:0]  mul_rmode;
  logic [31:0] mul_z;
  logic        mul_ovrf;
  logic        mul_udrf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_z;
  logic        rsp_ovrf;
  logic        rsp_udrf;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_rmode,
    input  req1_valid, req1_x, req1_y, req1_rmode,
    input  mul_z, mul_ovrf, mul_udrf, rsp_ready,
    output req0_ready, req1_ready, mul_x, mul_y, mul_rmode,
    output rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_rmode,
    output req1_valid, req1_x, req1_y, req1_rmode,
    output mul_z, mul_ovrf, mul_udrf, rsp_ready,
    input  req0_ready, req1_ready, mul_x, mul_y, mul_rmode,
    input  rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, busy
  );
endinterface

// File: rtl/fp_mul_arbiter_rr_arb2.sv
// rtl/fp_mul_arbiter_rr_arb2.sv - two-input round-robin grant, pointer moves only on a contested accept
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // An uncontested grant leaves the preference where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rr_ptr <= 1'b0;
    else if (en && (req == 2'b11))   rr_ptr <= ~rr_ptr;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - shares one combinational FP32 multiplier between two requesters
module fp_mul_arbiter
  import fp_mul_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  fp_mul_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       grant;
  logic             idle, cnt_done;
  logic [31:0]      sel_x, sel_y;
  logic [2:0]       sel_rmode;
  logic [31:0]      mul_x_q, mul_y_q, rsp_z_q;
  logic [2:0]       mul_rmode_q;
  logic             rsp_id_q, rsp_ovrf_q, rsp_udrf_q, rsp_err_q;

  assign idle     = (state_q == ST_IDLE);
  assign cnt_done = (cnt_q == CNT_W'(MUL_LAT - 1));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign sel_x     = grant[1] ? bus.req1_x     : bus.req0_x;
  assign sel_y     = grant[1] ? bus.req1_y     : bus.req0_y;
  assign sel_rmode = grant[1] ? bus.req1_rmode : bus.req0_rmode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|grant) state_d = rmode_legal(sel_rmode) ? ST_CALC : ST_DONE;
      ST_CALC: if (cnt_done) state_d = ST_DONE;
      ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_rmode_q <= '0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
      rsp_ovrf_q  <= 1'b0;
      rsp_udrf_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (|grant) begin
          mul_x_q     <= sel_x;
          mul_y_q     <= sel_y;
          mul_rmode_q <= sel_rmode;
          rsp_id_q    <= grant[1];
          cnt_q       <= '0;
          // Rejected modes skip the multiplier and answer with a quiet NaN.
          if (!rmode_legal(sel_rmode)) begin
            rsp_z_q    <= QNAN;
            rsp_ovrf_q <= 1'b0;
            rsp_udrf_q <= 1'b0;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_done) begin
            rsp_z_q    <= bus.mul_z;
            rsp_ovrf_q <= bus.mul_ovrf;
            rsp_udrf_q <= bus.mul_udrf;
            rsp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.mul_x      = mul_x_q;
  assign bus.mul_y      = mul_y_q;
  assign bus.mul_rmode  = mul_rmode_q;
  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_ovrf   = rsp_ovrf_q;
  assign bus.rsp_udrf   = rsp_udrf_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - directed self-checking bench for fp_mul_arbiter at MUL_LAT 1 and 3
module tb_fp_mul_arbiter;

  logic clk = 1'b0;
  logic rst_n1, rst_n3;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter_if if1();
  fp_mul_arbiter_if if3();

  fp_mul_arbiter #(.MUL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1));
  fp_mul_arbiter #(.MUL_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n3), .bus(if3));

  // Known-answer stand-in for the multiplier; unknown operands give a poison value.
  function automatic logic [33:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h40400000 && y == 32'h40400000) return {32'h41100000, 2'b00};
    if (x == 32'h3f800000 && y == 32'h40490fdb) return {32'h40490fdb, 2'b00};
    if (x == 32'h7f000000 && y == 32'h7f000000) return {32'h7f800000, 2'b10};
    return {32'hdeadbeef, 2'b11};
  endfunction

  always_comb {if1.mul_z, if1.mul_ovrf, if1.mul_udrf} = mul_model(if1.mul_x, if1.mul_y);
  always_comb {if3.mul_z, if3.mul_ovrf, if3.mul_udrf} = mul_model(if3.mul_x, if3.mul_y);

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    if1.req0_valid = 0; if1.req1_valid = 0; if1.rsp_ready = 0;
    if1.req0_x = 0; if1.req0_y = 0; if1.req0_rmode = 0;
    if1.req1_x = 0; if1.req1_y = 0; if1.req1_rmode = 0;
    if3.req0_valid = 0; if3.req1_valid = 0; if3.rsp_ready = 0;
    if3.req0_x = 0; if3.req0_y = 0; if3.req0_rmode = 0;
    if3.req1_x = 0; if3.req1_y = 0; if3.req1_rmode = 0;
    rst_n1 = 0; rst_n3 = 0;
    step(); step();
    chk("reset_rsp_valid", {31'b0, if1.rsp_valid}, 32'd0);
    chk("reset_busy", {31'b0, if1.busy}, 32'd0);
    chk("reset_mul_x", if1.mul_x, 32'd0);
    chk("reset_rsp_z", if1.rsp_z, 32'd0);
    chk("reset_flags", {28'b0, if1.rsp_id, if1.rsp_ovrf, if1.rsp_udrf, if1.rsp_err}, 32'd0);
    rst_n1 = 1; rst_n3 = 1;
    step();
  endtask

  task automatic test_basic;
    if1.rsp_ready = 1;
    if1.req0_x = 32'h40400000; if1.req0_y = 32'h40400000; if1.req0_rmode = 3'b001;
    if1.req0_valid = 1;
    #1;
    chk("basic_ready_t", {31'b0, if1.req0_ready}, 32'd1);
    step();
    if1.req0_valid = 0;
    chk("basic_valid_t1", {31'b0, if1.rsp_valid}, 32'd0);
    chk("basic_busy_t1", {31'b0, if1.busy}, 32'd1);
    chk("basic_mul_x", if1.mul_x, 32'h40400000);
    chk("basic_mul_rmode", {29'b0, if1.mul_rmode}, 32'd1);
    step();
    chk("basic_valid_t2", {31'b0, if1.rsp_valid}, 32'd1);
    chk("basic_z", if1.rsp_z, 32'h41100000);
    chk("basic_id_flags", {28'b0, if1.rsp_id, if1.rsp_ovrf, if1.rsp_udrf, if1.rsp_err}, 32'd0);
    step();
    chk("basic_valid_t3", {31'b0, if1.rsp_valid}, 32'd0);
  endtask

  task automatic test_fairness;
    int n;
    if1.rsp_ready = 1;
    if1.req0_x = 32'h40400000; if1.req0_y = 32'h40400000; if1.req0_rmode = 3'b001;
    if1.req1_x = 32'h3f800000; if1.req1_y = 32'h40490fdb; if1.req1_rmode = 3'b000;
    if1.req0_valid = 1; if1.req1_valid = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(if1.req0_ready || if1.req1_ready) && n < 10) begin step(); n++; end
      chk("fair_grant", {30'b0, if1.req1_ready, if1.req0_ready}, (k % 2 == 1) ? 32'd2 : 32'd1);
      step();
      n = 0;
      while (!if1.rsp_valid && n < 10) begin step(); n++; end
      chk("fair_rsp_seen", {31'b0, if1.rsp_valid}, 32'd1);
      chk("fair_rsp_id", {31'b0, if1.rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("fair_rsp_z", if1.rsp_z, (k % 2 == 1) ? 32'h40490fdb : 32'h41100000);
      if (k == 3) begin if1.req0_valid = 0; if1.req1_valid = 0; end
      step();
    end
  endtask

  task automatic test_overflow;
    if1.rsp_ready = 1;
    if1.req1_x = 32'h7f000000; if1.req1_y = 32'h7f000000; if1.req1_rmode = 3'b000;
    if1.req1_valid = 1;
    #1;
    chk("ovf_ready", {30'b0, if1.req1_ready, if1.req0_ready}, 32'd2);
    step();
    if1.req1_valid = 0;
    step();
    chk("ovf_valid", {31'b0, if1.rsp_valid}, 32'd1);
    chk("ovf_z", if1.rsp_z, 32'h7f800000);
    chk("ovf_id_flags", {28'b0, if1.rsp_id, if1.rsp_ovrf, if1.rsp_udrf, if1.rsp_err}, 32'b1100);
    step();
  endtask

  task automatic test_illegal_rmode;
    if1.rsp_ready = 1;
    if1.req0_x = 32'h12345678; if1.req0_y = 32'h12345678; if1.req0_rmode = 3'b110;
    if1.req0_valid = 1;
    #1;
    chk("ill_ready", {31'b0, if1.req0_ready}, 32'd1);
    step();
    if1.req0_valid = 0;
    chk("ill_valid_t1", {31'b0, if1.rsp_valid}, 32'd1);
    chk("ill_z", if1.rsp_z, 32'h7fc00000);
    chk("ill_id_flags", {28'b0, if1.rsp_id, if1.rsp_ovrf, if1.rsp_udrf, if1.rsp_err}, 32'b0001);
    step();
    chk("ill_valid_t2", {31'b0, if1.rsp_valid}, 32'd0);
  endtask

  task automatic test_backpressure;
    if1.rsp_ready = 0;
    if1.req0_x = 32'h40400000; if1.req0_y = 32'h40400000; if1.req0_rmode = 3'b011;
    if1.req0_valid = 1;
    #1;
    chk("bp_ready", {31'b0, if1.req0_ready}, 32'd1);
    step();
    if1.req0_valid = 0;
    step();
    chk("bp_valid", {31'b0, if1.rsp_valid}, 32'd1);
    if1.req1_x = 32'h3f800000; if1.req1_y = 32'h40490fdb; if1.req1_rmode = 3'b000;
    if1.req0_valid = 1; if1.req1_valid = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_z", if1.rsp_z, 32'h41100000);
      chk("bp_hold_state", {27'b0, if1.rsp_valid, if1.busy, if1.req1_ready, if1.req0_ready, if1.rsp_err},
          32'b11000);
    end
    if1.rsp_ready = 1;
    #1;
    chk("bp_release_nogrant", {30'b0, if1.req1_ready, if1.req0_ready}, 32'd0);
    step();
    chk("bp_idle_valid", {31'b0, if1.rsp_valid}, 32'd0);
    chk("bp_new_grant", {30'b0, if1.req1_ready, if1.req0_ready}, 32'd1);
    if1.req0_valid = 0; if1.req1_valid = 0;
    step();
  endtask

  task automatic test_reset_mid_calc;
    logic seen;
    if3.rsp_ready = 1;
    if3.req0_x = 32'h40400000; if3.req0_y = 32'h40400000; if3.req0_rmode = 3'b000;
    if3.req1_x = 32'h3f800000; if3.req1_y = 32'h40490fdb; if3.req1_rmode = 3'b000;
    if3.req0_valid = 1; if3.req1_valid = 1;
    #1;
    chk("rst3_first_grant", {30'b0, if3.req1_ready, if3.req0_ready}, 32'd1);
    step();
    if3.req0_valid = 0; if3.req1_valid = 0;
    chk("rst3_in_calc", {31'b0, if3.busy}, 32'd1);
    rst_n3 = 0;
    #1;
    chk("rst3_busy", {31'b0, if3.busy}, 32'd0);
    chk("rst3_mul_x", if3.mul_x, 32'd0);
    chk("rst3_mul_y", if3.mul_y, 32'd0);
    chk("rst3_outs", {27'b0, if3.rsp_valid, if3.rsp_id, if3.rsp_ovrf, if3.rsp_udrf, if3.rsp_err}, 32'd0);
    step();
    rst_n3 = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (if3.rsp_valid) seen = 1;
    end
    chk("rst3_no_rsp", {31'b0, seen}, 32'd0);
    if3.req0_valid = 1; if3.req1_valid = 1;
    #1;
    chk("rst3_grant_req0", {30'b0, if3.req1_ready, if3.req0_ready}, 32'd1);
    step();
    if3.req0_valid = 0; if3.req1_valid = 0;
    step(); step();
    chk("lat3_valid_t3", {31'b0, if3.rsp_valid}, 32'd0);
    step();
    chk("lat3_valid_t4", {31'b0, if3.rsp_valid}, 32'd1);
    chk("lat3_z", if3.rsp_z, 32'h41100000);
    chk("lat3_id", {31'b0, if3.rsp_id}, 32'd0);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_overflow();
    test_illegal_rmode();
    test_backpressure();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
